// File: rtl/ex_stage_if.sv
// Handshake and operand bus between decode, the execute stage and its consumer.
// The master side is the surrounding pipeline; the slave side is the execute stage.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic            id_ready;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [2:0]      alu_control;
  logic [1:0]      branch_op;
  logic            sltc;
  logic            arith_shift;
  logic            is_branch;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_result;
  logic [4:0]      ex_rd;
  logic            ex_br_taken;
  logic [XLEN-1:0] ex_br_target;

  modport master (
    output id_valid, flush, op_a, op_b, alu_control, branch_op, sltc,
           arith_shift, is_branch, pc, imm, rd, ex_ready,
    input  id_ready, ex_valid, ex_result, ex_rd, ex_br_taken, ex_br_target
  );

  modport slave (
    input  id_valid, flush, op_a, op_b, alu_control, branch_op, sltc,
           arith_shift, is_branch, pc, imm, rd, ex_ready,
    output id_ready, ex_valid, ex_result, ex_rd, ex_br_taken, ex_br_target
  );
endinterface

// File: rtl/ex_stage.sv
// Single-entry execute stage: ALU, set-less-than and branch resolution with a
// valid/ready output register and a flush that kills both held and offered ops.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  ex_stage_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUBS = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_SUBU = 3'b011,
    ALU_SRX  = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_op_e;

  alu_op_e         alu_op;
  br_op_e          br_op;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_value;
  logic [XLEN-1:0] result_next;
  logic            zero;
  logic            lt;
  logic            taken_next;
  logic            accept;

  assign alu_op = alu_op_e'(bus.alu_control);
  assign br_op  = br_op_e'(bus.branch_op);
  assign shamt  = bus.op_b[SHW-1:0];
  assign zero   = (bus.op_a == bus.op_b);

  // A new op may enter whenever the output register is empty or draining now.
  assign bus.id_ready = !bus.ex_valid || bus.ex_ready;
  assign accept       = bus.id_valid && bus.id_ready && !bus.flush;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    alu_value = '0;
    lt        = 1'b0;
    unique case (alu_op)
      ALU_ADD:  alu_value = bus.op_a + bus.op_b;
      ALU_SUBS: begin
        alu_value = bus.op_a - bus.op_b;
        lt        = $signed(bus.op_a) < $signed(bus.op_b);
      end
      ALU_SLL:  alu_value = bus.op_a << shamt;
      ALU_SUBU: begin
        alu_value = bus.op_a - bus.op_b;
        lt        = bus.op_a < bus.op_b;
      end
      ALU_SRX:  alu_value = bus.arith_shift ? XLEN'($signed(bus.op_a) >>> shamt)
                                            : bus.op_a >> shamt;
      ALU_XOR:  alu_value = bus.op_a ^ bus.op_b;
      ALU_OR:   alu_value = bus.op_a | bus.op_b;
      ALU_AND:  alu_value = bus.op_a & bus.op_b;
      default:  alu_value = '0;
    endcase
  end

  always_comb begin
    taken_next = 1'b0;
    if (bus.is_branch) begin
      unique case (br_op)
        BR_EQ:   taken_next = zero;
        BR_NE:   taken_next = !zero;
        BR_LT:   taken_next = lt;
        BR_GE:   taken_next = !lt;
        default: taken_next = 1'b0;
      endcase
    end
  end

  assign result_next = bus.sltc ? {{(XLEN-1){1'b0}}, lt} : alu_value;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_result    <= '0;
      bus.ex_rd        <= '0;
      bus.ex_br_taken  <= 1'b0;
      bus.ex_br_target <= '0;
    end else begin
      // Flush wins over both a concurrent accept and a stalled hold.
      if (bus.flush)         bus.ex_valid <= 1'b0;
      else if (accept)       bus.ex_valid <= 1'b1;
      else if (bus.ex_ready) bus.ex_valid <= 1'b0;

      if (accept) begin
        bus.ex_result    <= result_next;
        bus.ex_rd        <= bus.rd;
        bus.ex_br_taken  <= taken_next;
        bus.ex_br_target <= bus.pc + bus.imm;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases plus a randomized run
// scored against a transaction-level model of the stage.
module tb_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(XLEN)) bus ();
  ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t mdl;
  bit   mdl_valid = 1'b0;

  // Expected outcome of the currently offered operation, from the ISA rules.
  function automatic exp_t reference();
    exp_t        e;
    logic [31:0] a, b, alu, fill;
    int unsigned sh;
    bit          lt;
    a  = bus.op_a;
    b  = bus.op_b;
    sh = b % 32;
    lt = 1'b0;
    if (bus.alu_control == 3'd1) lt = ($signed(a) < $signed(b));
    if (bus.alu_control == 3'd3) lt = (a < b);
    case (bus.alu_control)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = 32'(longint'(a) * (longint'(1) << sh));
      3'd3:    alu = a - b;
      3'd4: begin
        fill = (bus.arith_shift && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        alu  = (a / (32'd1 << sh)) | fill;
      end
      3'd5:    alu = a ^ b;
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
    e.result = bus.sltc ? {31'b0, lt} : alu;
    e.rd     = bus.rd;
    case (bus.branch_op)
      2'd0:    e.taken = (a == b);
      2'd1:    e.taken = (a != b);
      2'd2:    e.taken = lt;
      default: e.taken = !lt;
    endcase
    if (!bus.is_branch) e.taken = 1'b0;
    e.target = bus.pc + bus.imm;
    return e;
  endfunction

  task automatic set_op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic sl, input logic ar, input logic br, input logic [1:0] bop,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    bus.id_valid    = 1'b1;
    bus.alu_control = ctl;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.sltc        = sl;
    bus.arith_shift = ar;
    bus.is_branch   = br;
    bus.branch_op   = bop;
    bus.pc          = pc;
    bus.imm         = imm;
    bus.rd          = rd;
  endtask

  // Advance one clock edge and move the model by the transaction rules.
  task automatic tick();
    exp_t e;
    bit   acc, cons;
    e    = reference();
    acc  = bus.id_valid && (!mdl_valid || bus.ex_ready) && !bus.flush;
    cons = mdl_valid && bus.ex_ready;
    @(posedge clk);
    if (bus.flush) mdl_valid = 1'b0;
    else if (acc) begin
      mdl       = e;
      mdl_valid = 1'b1;
    end else if (cons) mdl_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.id_valid = 0; bus.flush = 0; bus.ex_ready = 0;
    bus.op_a = 0; bus.op_b = 0; bus.alu_control = 0; bus.branch_op = 0;
    bus.sltc = 0; bus.arith_shift = 0; bus.is_branch = 0;
    bus.pc = 0; bus.imm = 0; bus.rd = 0;
    #1;
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.ex_valid); end
    n_cmp++; if ({bus.ex_result, bus.ex_rd, bus.ex_br_taken, bus.ex_br_target} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h/%b/%h expected all zero",
                        bus.ex_result, bus.ex_rd, bus.ex_br_taken, bus.ex_br_target);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_valid = 1'b0;
    #1;
  endtask

  task automatic test_directed();
    bus.ex_ready = 1'b1;
    set_op(3'd0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd3);
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b1) begin n_bad++; $display("FAIL add_wrap_valid: got %b expected 1", bus.ex_valid); end
    n_cmp++; if (bus.ex_result !== 32'h0) begin n_bad++; $display("FAIL add_wrap_result: got %h expected 00000000", bus.ex_result); end
    bus.id_valid = 1'b0;
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL add_one_cycle_valid: got %b expected 0", bus.ex_valid); end

    // Back-to-back: each edge consumes the previous result and loads the next.
    set_op(3'd1, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 2'd0, 32'h0, 32'h0, 5'd4);
    tick();
    n_cmp++; if (bus.ex_result !== 32'h1) begin n_bad++; $display("FAIL slt_signed: got %h expected 00000001", bus.ex_result); end
    set_op(3'd3, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 2'd0, 32'h0, 32'h0, 5'd5);
    tick();
    n_cmp++; if (bus.ex_result !== 32'h0 || bus.ex_valid !== 1'b1) begin
      n_bad++; $display("FAIL slt_unsigned: got %h valid %b expected 00000000 valid 1", bus.ex_result, bus.ex_valid);
    end
    set_op(3'd4, 32'h8000_0000, 32'h4, 0, 1, 0, 2'd0, 32'h0, 32'h0, 5'd6);
    tick();
    n_cmp++; if (bus.ex_result !== 32'hF800_0000) begin n_bad++; $display("FAIL sra: got %h expected f8000000", bus.ex_result); end
    set_op(3'd4, 32'h8000_0000, 32'h4, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd6);
    tick();
    n_cmp++; if (bus.ex_result !== 32'h0800_0000) begin n_bad++; $display("FAIL srl: got %h expected 08000000", bus.ex_result); end
    set_op(3'd3, 32'h5, 32'h5, 0, 0, 1, 2'd3, 32'h100, 32'hFFFF_FFF8, 5'd7);
    tick();
    n_cmp++; if (bus.ex_br_taken !== 1'b1) begin n_bad++; $display("FAIL bge_taken: got %b expected 1", bus.ex_br_taken); end
    n_cmp++; if (bus.ex_br_target !== 32'h0000_00F8) begin n_bad++; $display("FAIL bge_target: got %h expected 000000f8", bus.ex_br_target); end
    set_op(3'd3, 32'h5, 32'h5, 0, 0, 0, 2'd3, 32'h100, 32'hFFFF_FFF8, 5'd7);
    tick();
    n_cmp++; if (bus.ex_br_taken !== 1'b0 || bus.ex_br_target !== 32'h0000_00F8) begin
      n_bad++; $display("FAIL not_branch: got taken %b target %h expected 0 / 000000f8", bus.ex_br_taken, bus.ex_br_target);
    end
    bus.id_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    bus.ex_ready = 1'b1;
    set_op(3'd0, 32'd3, 32'd4, 0, 0, 0, 2'd0, 32'h40, 32'h8, 5'd7);
    tick();
    bus.ex_ready = 1'b0;
    set_op(3'd5, 32'h0000_F0F0, 32'h0000_0FF0, 0, 0, 0, 2'd0, 32'h80, 32'h4, 5'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL stall_id_ready[%0d]: got %b expected 0", i, bus.id_ready); end
      tick();
      n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_result !== 32'd7 || bus.ex_rd !== 5'd7 || bus.ex_br_target !== 32'h48) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v%b %h rd%0d %h expected v1 00000007 rd7 00000048",
                          i, bus.ex_valid, bus.ex_result, bus.ex_rd, bus.ex_br_target);
      end
    end
    bus.ex_ready = 1'b1;
    #1;
    n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL drain_id_ready: got %b expected 1", bus.id_ready); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_result !== 32'h0000_FF00 || bus.ex_rd !== 5'd9) begin
      n_bad++; $display("FAIL drain_load: got v%b %h rd%0d expected v1 0000ff00 rd9", bus.ex_valid, bus.ex_result, bus.ex_rd);
    end
    bus.id_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_reset();
    bus.ex_ready = 1'b1;
    set_op(3'd6, 32'h1, 32'h2, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd1);
    tick();
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    set_op(3'd0, 32'h10, 32'h20, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd2);
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_kill: got %b expected 0", bus.ex_valid); end
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_accept: got %b expected 0", bus.ex_valid); end

    set_op(3'd0, 32'h1, 32'h2, 0, 0, 1, 2'd1, 32'h200, 32'h4, 5'd5);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({bus.ex_valid, bus.ex_result, bus.ex_rd, bus.ex_br_taken, bus.ex_br_target} !== '0) begin
      n_bad++; $display("FAIL async_reset: got v%b %h rd%0d t%b %h expected all zero",
                        bus.ex_valid, bus.ex_result, bus.ex_rd, bus.ex_br_taken, bus.ex_br_target);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    mdl_valid = 1'b0;
    set_op(3'd0, 32'h30, 32'h12, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd11);
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_result !== 32'h42 || bus.ex_rd !== 5'd11) begin
      n_bad++; $display("FAIL post_reset_accept: got v%b %h rd%0d expected v1 00000042 rd11", bus.ex_valid, bus.ex_result, bus.ex_rd);
    end
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      set_op(3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 32'($urandom), 32'($urandom), 5'($urandom));
      bus.id_valid = ($urandom_range(0, 9) < 7);
      bus.ex_ready = ($urandom_range(0, 9) < 6);
      bus.flush    = ($urandom_range(0, 19) == 0);
      #1;
      n_cmp++; if (bus.id_ready !== (!mdl_valid || bus.ex_ready)) begin
        n_bad++; $display("FAIL rand_id_ready[%0d]: got %b expected %b", i, bus.id_ready, !mdl_valid || bus.ex_ready);
      end
      tick();
      n_cmp++; if (bus.ex_valid !== mdl_valid) begin
        n_bad++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, bus.ex_valid, mdl_valid);
      end
      if (mdl_valid) begin
        n_cmp++; if ({bus.ex_result, bus.ex_rd, bus.ex_br_taken, bus.ex_br_target} !== mdl) begin
          n_bad++; $display("FAIL rand_data[%0d]: got %h rd%0d t%b %h expected %h rd%0d t%b %h", i,
                            bus.ex_result, bus.ex_rd, bus.ex_br_taken, bus.ex_br_target,
                            mdl.result, mdl.rd, mdl.taken, mdl.target);
        end
      end
    end
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset; one clock, no other reset.
REQ-004 id_valid  input  1  decode stage offers an operation this cycle.
REQ-005 id_ready  output  1  stage can accept the offered operation this cycle.
REQ-006 flush  input  1  kill the held operation and the operation offered this cycle.
REQ-007 op_a, op_b  input  XLEN each  source operands; op_b is register or immediate, already selected.
REQ-008 alu_control  input  3  000 ADD, 001 SUB signed, 010 SLL, 011 SUB unsigned, 100 SRL/SRA, 101 XOR, 110 OR, 111 AND.
REQ-009 branch_op  input  2  00 EQ, 01 NE, 10 LT, 11 GE.
REQ-010 sltc  input  1  result is the set-less-than bit instead of the ALU value.
REQ-011 arith_shift  input  1  with alu_control 100: 1 SRA, 0 SRL.
REQ-012 is_branch  input  1  operation is a conditional branch.
REQ-013 pc, imm  input  XLEN each  branch instruction address and sign-extended offset.
REQ-014 rd  input  5  destination register tag, carried through unchanged.
REQ-015 ex_valid  output  1  result registers hold a live operation.
REQ-016 ex_ready  input  1  downstream consumes the result this cycle.
REQ-017 ex_result  output  XLEN  registered ALU or SLT result.
REQ-018 ex_rd  output  5  registered destination tag.
REQ-019 ex_br_taken  output  1  registered branch decision; 0 unless is_branch.
REQ-020 ex_br_target  output  XLEN  registered pc+imm, modulo 2^XLEN.

Function
REQ-021 id_ready SHALL be combinational: !ex_valid || ex_ready.
REQ-022 An operation SHALL be accepted on a rising edge where id_valid && id_ready && !flush.
REQ-023 Latency SHALL be one cycle: an operation accepted at edge N appears on the ex_* outputs after edge N with ex_valid=1.
REQ-024 ex_valid SHALL stay 1 and all ex_* outputs SHALL hold until an edge where ex_ready=1 (no loss, no duplication).
REQ-025 Simultaneous consume and accept SHALL load the new operation with ex_valid staying 1; consume without accept SHALL clear ex_valid.
REQ-026 ADD, SUB and XOR/OR/AND SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-027 Shift amount SHALL be op_b[4:0] for XLEN=32 (log2 XLEN bits); SRA SHALL replicate op_a[XLEN-1].
REQ-028 zero SHALL be (op_a == op_b).
REQ-029 lt SHALL be the signed comparison op_a<op_b for alu_control 001, unsigned for 011, and 0 for every other code.
REQ-030 With sltc=1, ex_result SHALL be lt zero-extended to XLEN; with sltc=0, ex_result SHALL be the ALU value.
REQ-031 Branch taken SHALL be: EQ zero; NE !zero; LT lt; GE !lt; and SHALL be forced to 0 when is_branch=0.
REQ-032 ex_br_target SHALL be registered on every accept, regardless of is_branch.
REQ-033 When flush=1 at an edge, ex_valid SHALL be 0 after that edge; flush SHALL override any concurrent accept or hold.
REQ-034 Data registers SHALL load only on accept; while ex_valid=0 their values are don't-care for the consumer.

Reset
REQ-035 While rst_n=0, ex_valid, ex_br_taken, ex_result, ex_rd and ex_br_target SHALL be 0 immediately, independent of clk.
REQ-036 Reset asserted while an operation is held SHALL discard it; the first edge after release with id_valid=1 SHALL accept normally.

Verification
REQ-037 ADD 0xFFFFFFFF+0x00000001, ex_ready=1 -> ex_result=0x00000000 one cycle later, ex_valid=1 for exactly one cycle.
REQ-038 SLT signed a=0xFFFFFFFF, b=1, sltc=1 -> result 1; same operands with alu_control 011 -> result 0.
REQ-039 SRA a=0x80000000, b=4 -> 0xF8000000; SRL with the same operands -> 0x08000000.
REQ-040 Branch GE unsigned, a=5, b=5, pc=0x100, imm=0xFFFFFFF8 -> br_taken=1, target=0x000000F8; is_branch=0 -> br_taken=0.
REQ-041 ex_ready held 0 for 3 cycles with id_valid=1 -> id_ready=0, outputs frozen; ex_ready=1 -> held result consumed and next operation loaded on the same edge.
REQ-042 flush with id_valid=1 while a result is held -> ex_valid=0 next cycle and nothing accepted; rst_n pulse mid-stall -> all outputs 0 asynchronously.
